servo_ramp: RTL and testbench

//  Upstream command stage for the servo PWM generator. Accepts a target angle in degrees

---
 rtl/servo_pkg.sv | 20 ++
 rtl/servo_div.sv | 54 +++++
 rtl/servo_ramp.sv | 100 ++++++++++
 tb/tb_servo_ramp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and state encoding for the servo command ramp
package servo_pkg;

  localparam int DEF_PERIOD_CNT = 20000;
  localparam int DEF_MIN_PW     = 500;
  localparam int DEF_MAX_PW     = 2500;
  localparam int DEF_CENTER_PW  = 1500;
  localparam int DEF_STEP_PW    = 10;
  localparam int MAX_DEG        = 180;
  localparam int DIV_W          = 20;
  // 12 bits hold any pulse width up to MAX_PW; angle_num[31:12] is tied low
  localparam int PW_W           = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RAMP = 2'd2
  } state_t;

endpackage

// File: rtl/servo_div.sv
// rtl/servo_div.sv - unsigned restoring shift-subtract divider, done 20 cycles after start
module servo_div
  import servo_pkg::*;
(
  input  logic             clk_1m,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  logic [DIV_W-1:0] rem, quo, src_rem, src_quo, nxt_rem, nxt_quo;
  logic [DIV_W:0]   trial;
  logic [4:0]       cnt;

  // The first iteration runs on the start edge itself so done lands exactly DIV_W cycles later
  always_comb begin
    src_rem = start ? '0 : rem;
    src_quo = start ? dividend : quo;
    trial   = {src_rem, src_quo[DIV_W-1]} - {1'b0, divisor};
    if (!trial[DIV_W]) nxt_rem = trial[DIV_W-1:0];
    else               nxt_rem = {src_rem[DIV_W-2:0], src_quo[DIV_W-1]};
    nxt_quo = {src_quo[DIV_W-2:0], ~trial[DIV_W]};
  end

  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= nxt_rem;
      quo  <= nxt_quo;
      cnt  <= 5'(DIV_W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        rem <= nxt_rem;
        quo <= nxt_quo;
        cnt <= cnt - 5'd1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done     = busy && (cnt == '0);
  assign quotient = quo;

endmodule

// File: rtl/servo_ramp.sv
// rtl/servo_ramp.sv - angle command to pulse width converter with per-frame slew limit
module servo_ramp
  import servo_pkg::*;
#(
  parameter int PERIOD_CNT = DEF_PERIOD_CNT,
  parameter int MIN_PW     = DEF_MIN_PW,
  parameter int MAX_PW     = DEF_MAX_PW,
  parameter int CENTER_PW  = DEF_CENTER_PW,
  parameter int STEP_PW    = DEF_STEP_PW
) (
  input  logic        clk_1m,
  input  logic        rst,
  input  logic [7:0]  angle_deg,
  input  logic        angle_valid,
  output logic        angle_ready,
  output logic [31:0] angle_num,
  output logic        at_target,
  output logic        frame_tick
);

  localparam int CW = (PERIOD_CNT > 2) ? $clog2(PERIOD_CNT) : 1;
  localparam logic signed [PW_W:0] STEP_S = (PW_W+1)'(STEP_PW);

  state_t            state, state_nxt;
  logic [CW-1:0]     frame_cnt;
  logic [PW_W-1:0]   pw, target, conv_pw;
  logic signed [PW_W:0] diff;
  logic              accept, near;
  logic [7:0]        deg_c;
  logic [DIV_W-1:0]  dividend, div_quo;
  logic              div_busy, div_done;

  // frame_tick is registered one count early so it is high while frame_cnt == PERIOD_CNT-1
  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_cnt  <= (frame_cnt == CW'(PERIOD_CNT - 1)) ? '0 : frame_cnt + 1'b1;
      frame_tick <= (frame_cnt == CW'(PERIOD_CNT - 2));
    end
  end

  assign angle_ready = (state != S_CONV) && !div_busy;
  assign accept      = angle_valid && angle_ready;
  assign deg_c       = (angle_deg > 8'(MAX_DEG)) ? 8'(MAX_DEG) : angle_deg;
  assign dividend    = DIV_W'(deg_c) * DIV_W'(MAX_PW - MIN_PW);
  assign conv_pw     = PW_W'(MIN_PW + int'(div_quo));

  servo_div u_div (
    .clk_1m   (clk_1m),
    .rst      (rst),
    .start    (accept),
    .dividend (dividend),
    .divisor  (DIV_W'(MAX_DEG)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign diff = $signed({1'b0, target}) - $signed({1'b0, pw});
  assign near = (diff <= STEP_S) && (diff >= -STEP_S);

  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CONV;
      S_CONV:  if (div_done) state_nxt = S_RAMP;
      S_RAMP: begin
        if (accept)                  state_nxt = S_CONV;
        else if (frame_tick && near) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A command accepted on a tick cycle pre-empts that frame's step
  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      pw     <= PW_W'(CENTER_PW);
      target <= PW_W'(CENTER_PW);
    end else begin
      if (state == S_CONV && div_done) target <= conv_pw;
      if (state == S_RAMP && !accept && frame_tick) begin
        if (near)         pw <= target;
        else if (diff[PW_W]) pw <= pw - PW_W'(STEP_PW);
        else              pw <= pw + PW_W'(STEP_PW);
      end
    end
  end

  assign angle_num = {{(32-PW_W){1'b0}}, pw};
  assign at_target = (state == S_IDLE);

endmodule

// File: tb/tb_servo_ramp.sv
// tb/tb_servo_ramp.sv - randomized self-checking bench for servo_ramp against a behavioural model
module tb_servo_ramp;

  localparam int TP = 30;

  logic        clk_1m = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  angle_deg = 8'd0;
  logic        angle_valid = 1'b0;
  logic        angle_ready;
  logic [31:0] angle_num;
  logic        at_target;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk_1m = ~clk_1m;

  servo_ramp #(.PERIOD_CNT(TP)) dut (
    .clk_1m      (clk_1m),
    .rst         (rst),
    .angle_deg   (angle_deg),
    .angle_valid (angle_valid),
    .angle_ready (angle_ready),
    .angle_num   (angle_num),
    .at_target   (at_target),
    .frame_tick  (frame_tick)
  );

  function automatic int deg_to_pw(input int deg);
    int d;
    d = (deg > 180) ? 180 : deg;
    return 500 + (d * 2000) / 180;
  endfunction

  // behavioural model: pending conversion countdown, target, current width, settled flag
  int m_num, m_target, m_pending, m_conv_left, m_fc;
  bit m_settled;

  always @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      m_num = 1500; m_target = 1500; m_pending = 1500;
      m_conv_left = 0; m_fc = 0; m_settled = 1;
    end else begin
      if (m_conv_left > 0) begin
        m_conv_left = m_conv_left - 1;
        if (m_conv_left == 0) m_target = m_pending;
      end else if (angle_valid) begin
        m_pending = deg_to_pw(int'(angle_deg));
        m_conv_left = 20;
        m_settled = 0;
      end else if (m_fc == TP - 1 && !m_settled) begin
        if (m_target - m_num <= 10 && m_num - m_target <= 10) begin
          m_num = m_target;
          m_settled = 1;
        end else if (m_target > m_num) m_num = m_num + 10;
        else m_num = m_num - 10;
      end
      m_fc = (m_fc + 1) % TP;
    end
  end

  // invariant monitor: width changes only right after a tick, by at most 10, within range
  int viol = 0;
  int prev_num = 1500;
  bit prev_tick = 0;
  always @(negedge clk_1m) begin
    if (rst) begin
      prev_num = int'(angle_num);
      prev_tick = 0;
    end else begin
      if (int'(angle_num) != prev_num) begin
        if (!prev_tick) viol++;
        if (int'(angle_num) - prev_num > 10 || prev_num - int'(angle_num) > 10) viol++;
      end
      if (angle_num < 32'd500 || angle_num > 32'd2500) viol++;
      prev_num = int'(angle_num);
      prev_tick = frame_tick;
    end
  end

  task automatic send(input int deg);
    int n = 0;
    while (!angle_ready && n < 100) begin @(negedge clk_1m); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_ready_timeout: angle_ready stayed %0b, required 1", angle_ready);
    end
    angle_deg = 8'(deg);
    angle_valid = 1'b1;
    @(negedge clk_1m);
    angle_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!frame_tick && n < 2 * TP) begin @(negedge clk_1m); n++; end
    if (!frame_tick) begin
      checks++; errors++;
      $display("FAIL tick_timeout: frame_tick %0b after %0d cycles, required 1", frame_tick, n);
    end
  endtask

  task automatic wait_settle();
    int n = 0;
    while (!at_target && n < 250 * TP) begin @(negedge clk_1m); n++; end
    if (!at_target) begin
      checks++; errors++;
      $display("FAIL settle_timeout: at_target %0b angle_num %0d, required at_target 1", at_target, angle_num);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk_1m);
    checks++; if (angle_num !== 32'd1500) begin errors++; $display("FAIL reset_num: got %0d required 1500", angle_num); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL reset_at_target: got %0b required 1", at_target); end
    checks++; if (angle_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", angle_ready); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b required 0", frame_tick); end
    rst = 1'b0;
    n = 0;
    while (!frame_tick && n < 3 * TP) begin @(negedge clk_1m); n++; end
    checks++; if (n != TP - 1) begin errors++; $display("FAIL first_tick_cycle: got %0d required %0d", n, TP - 1); end
    n = 0;
    do begin @(negedge clk_1m); n++; end while (!frame_tick && n < 3 * TP);
    checks++; if (n != TP) begin errors++; $display("FAIL tick_period: got %0d required %0d", n, TP); end
  endtask

  task automatic test_full_ramp();
    int n = 0;
    send(180);
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL conv_at_target: got %0b required 0", at_target); end
    while (!angle_ready && n < 40) begin n++; @(negedge clk_1m); end
    checks++; if (n != 20) begin errors++; $display("FAIL conv_length: got %0d required 20", n); end
    for (int k = 1; k <= 100; k++) begin
      wait_tick();
      @(negedge clk_1m);
      checks++;
      if (angle_num !== 32'(1500 + 10 * k)) begin
        errors++; $display("FAIL ramp_up_step%0d: got %0d required %0d", k, angle_num, 1500 + 10 * k);
      end
    end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL ramp_up_done: at_target %0b required 1", at_target); end
  endtask

  task automatic test_targets();
    int degs[3] = '{1, 255, 0};
    int want[3] = '{511, 2500, 500};
    for (int i = 0; i < 3; i++) begin
      send(degs[i]);
      wait_settle();
      checks++;
      if (angle_num !== 32'(want[i])) begin
        errors++; $display("FAIL target_deg%0d: got %0d required %0d", degs[i], angle_num, want[i]);
      end
      checks++;
      if (angle_num !== 32'(deg_to_pw(degs[i]))) begin
        errors++; $display("FAIL model_target_deg%0d: got %0d required %0d", degs[i], angle_num, deg_to_pw(degs[i]));
      end
    end
  endtask

  task automatic test_midramp();
    int n = 0;
    send(180);
    while (angle_num != 32'd1800 && n < 200 * TP) begin @(negedge clk_1m); n++; end
    checks++; if (angle_num !== 32'd1800) begin errors++; $display("FAIL midramp_reach: got %0d required 1800", angle_num); end
    send(0);
    n = 0;
    while (!angle_ready && n < 40) begin
      checks++;
      if (angle_num !== 32'd1800) begin errors++; $display("FAIL midramp_hold: got %0d required 1800", angle_num); end
      n++; @(negedge clk_1m);
    end
    for (int k = 1; k <= 2; k++) begin
      wait_tick();
      @(negedge clk_1m);
      checks++;
      if (angle_num !== 32'(1800 - 10 * k)) begin
        errors++; $display("FAIL midramp_down%0d: got %0d required %0d", k, angle_num, 1800 - 10 * k);
      end
    end
  endtask

  task automatic test_tick_accept();
    logic [31:0] held;
    int deg;
    wait_tick();
    held = angle_num;
    deg = int'($urandom_range(0, 255));
    angle_deg = 8'(deg);
    angle_valid = 1'b1;
    @(negedge clk_1m);
    angle_valid = 1'b0;
    checks++; if (angle_num !== held) begin errors++; $display("FAIL tick_accept_hold: got %0d required %0d", angle_num, held); end
    checks++; if (angle_ready !== 1'b0) begin errors++; $display("FAIL tick_accept_conv: ready %0b required 0", angle_ready); end
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL tick_accept_at_target: got %0b required 0", at_target); end
    wait_settle();
    checks++;
    if (angle_num !== 32'(deg_to_pw(deg))) begin
      errors++; $display("FAIL tick_accept_final deg%0d: got %0d required %0d", deg, angle_num, deg_to_pw(deg));
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        send(90);
        repeat (5) @(negedge clk_1m);
      end else begin
        send(180);
        while (angle_num < 32'd1600 && n < 200 * TP) begin @(negedge clk_1m); n++; end
      end
      rst = 1'b1;
      #1;
      checks++; if (angle_num !== 32'd1500) begin errors++; $display("FAIL rst_mid%0d_num: got %0d required 1500", pass, angle_num); end
      checks++; if (angle_ready !== 1'b1) begin errors++; $display("FAIL rst_mid%0d_ready: got %0b required 1", pass, angle_ready); end
      checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL rst_mid%0d_at_target: got %0b required 1", pass, at_target); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_mid%0d_tick: got %0b required 0", pass, frame_tick); end
      repeat (2) @(negedge clk_1m);
      rst = 1'b0;
    end
    send(45);
    wait_settle();
    checks++; if (angle_num !== 32'd1000) begin errors++; $display("FAIL rst_recover: got %0d required 1000", angle_num); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_1m);
      checks++;
      if (angle_num !== 32'(m_num)) begin errors++; $display("FAIL rand_num c%0d: got %0d required %0d", c, angle_num, m_num); end
      checks++;
      if (at_target !== (m_settled && m_conv_left == 0)) begin
        errors++; $display("FAIL rand_at_target c%0d: got %0b required %0b", c, at_target, m_settled && m_conv_left == 0);
      end
      checks++;
      if (angle_ready !== (m_conv_left == 0)) begin
        errors++; $display("FAIL rand_ready c%0d: got %0b required %0b", c, angle_ready, m_conv_left == 0);
      end
      checks++;
      if (frame_tick !== (m_fc == TP - 1)) begin
        errors++; $display("FAIL rand_tick c%0d: got %0b required %0b", c, frame_tick, m_fc == TP - 1);
      end
      angle_deg = 8'($urandom_range(0, 255));
      angle_valid = ($urandom_range(0, 39) == 0);
    end
    angle_valid = 1'b0;
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL invariants: got %0d violations required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_full_ramp();
    test_targets();
    test_midramp();
    test_tick_accept();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
